hex_seq_ctrl: RTL and testbench
===============================

HEX_SEQ_CTRL -- requirements
Module: hex_seq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the number of consecutive stable clock samples a key needs before its debounced level changes.
REQ-002 Parameter AUTO_PERIOD, default 25000000, SHALL set the number of clock cycles between automatic steps.
REQ-003 CLOCK_50  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 KEY  input  4  SHALL carry raw, asynchronous, active-low pushbuttons: KEY[0] = step, KEY[1] = clear, KEY[3:2] = unused.
REQ-006 SW  input  10  SHALL carry slide switches: SW[0] = direction (1 = up, 0 = down), SW[1] = auto-run enable, SW[9:2] = must be 0.
REQ-007 HEX0  output  7  SHALL be the registered, active-low seven-segment code (bit order g..a) of the current value.
REQ-008 value  output  3  SHALL be the registered current sequence value, 1..5.

Function
REQ-009 KEY[0] and KEY[1] SHALL each pass through a 2-flop synchronizer, then a debouncer; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive cycles of the new synchronized level.
REQ-010 A step request SHALL be a one-cycle pulse on the debounced KEY[0] 1->0 transition; holding the key SHALL produce no further pulses.
REQ-011 Clear SHALL be level-sensitive: while debounced KEY[1] = 0, value SHALL be forced to 1 and the auto timer to 0.
REQ-012 The FSM SHALL have states MANUAL, AUTO and ERROR.
REQ-013 Legal switches: SW[9:2] = 0. If illegal in any state -> ERROR next cycle.
REQ-014 Transitions from ERROR: legal and SW[1] = 0 -> MANUAL; legal and SW[1] = 1 -> AUTO. Between MANUAL and AUTO, SW[1] SHALL select the state each cycle.
REQ-015 MANUAL: each step pulse SHALL advance value by one in the SW[0] direction.
REQ-016 AUTO: step pulses SHALL be ignored; the timer counts 0..AUTO_PERIOD-1, and the cycle it equals AUTO_PERIOD-1 it SHALL wrap to 0 and advance value once.
REQ-017 The timer SHALL be zeroed on entry to AUTO from any other state.
REQ-018 Wrap: up 5 -> 1, down 1 -> 5; value SHALL never leave 1..5.
REQ-019 ERROR: value SHALL be held, steps and timer frozen, HEX0 SHALL show "E" = 7'b0000110; on leaving ERROR, HEX0 SHALL resume showing the held value.
REQ-020 Encoding: 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000, 4 = 7'b0011001, 5 = 7'b0010010.
REQ-021 Latency: HEX0 and value SHALL reflect an advance on the clock edge after the step pulse or timer wrap.
REQ-022 If clear and an advance occur in the same cycle, clear SHALL win.
REQ-023 If a switch change to an illegal setting coincides with an advance, ERROR SHALL win and value SHALL be held.

Reset
REQ-024 On reset assertion, without a clock edge, the block SHALL set: value = 1, HEX0 = 7'b1111001, state = MANUAL, timer = 0, synchronizers and debounced levels = 1 (released), debounce counters = 0.
REQ-025 Reset asserted mid-debounce or mid-period SHALL discard the partial count; there SHALL be no step on release.

Structure
REQ-026 A shared package hex_seq_pkg SHALL hold the state enumeration, the five segment constants and the ERR_SEG constant.
REQ-027 Sub-module key_debounce, containing the synchronizer, counter and falling-edge pulse, SHALL be instantiated once each for KEY[0] and KEY[1].
REQ-028 Counter widths SHALL be $clog2 of the respective parameter.

Verification (DEBOUNCE_CYCLES = 4, AUTO_PERIOD = 8)
REQ-029 Reset, SW = 0, hold KEY[0] low for 10 cycles then release -> value 1 -> 5 once only, HEX0 = 7'b0010010.
REQ-030 SW = 10'b1, five clean KEY[0] presses -> value sequence 2, 3, 4, 5, 1; a 2-cycle glitch on KEY[0] -> no step.
REQ-031 SW = 10'b10, run 40 cycles -> five advances spaced exactly 8 cycles apart, value back to 1; KEY[0] presses have no effect.
REQ-032 In AUTO, set SW[5] = 1 on the cycle the timer hits 7 -> HEX0 = 7'b0000110 and value held; restore SW -> held value shown, first advance 8 cycles later.
REQ-033 Hold KEY[1] low while stepping -> value stays 1; assert reset mid-period -> HEX0 = 7'b1111001 immediately, asynchronously.

Source files
------------

// File: rtl/hex_seq_pkg.sv
// Shared types and constants for the hex sequence controller.
// Holds the FSM states, the seven-segment codes and the value stepping helpers.
package hex_seq_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    ERROR  = 2'd2
  } state_t;

  // Active-low segment codes, bit order g..a
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] ERR_SEG = 7'b0000110;

  localparam logic [2:0] VAL_MIN = 3'd1;
  localparam logic [2:0] VAL_MAX = 3'd5;

  function automatic logic [6:0] seg_of(input logic [2:0] v);
    logic [6:0] seg;
    case (v)
      3'd2:    seg = SEG_2;
      3'd3:    seg = SEG_3;
      3'd4:    seg = SEG_4;
      3'd5:    seg = SEG_5;
      default: seg = SEG_1;
    endcase
    return seg;
  endfunction

  // One step around the 1..5 ring in the requested direction
  function automatic logic [2:0] next_value(input logic [2:0] v, input logic up);
    logic [2:0] n;
    if (up) n = (v >= VAL_MAX) ? VAL_MIN : v + 3'd1;
    else    n = (v <= VAL_MIN) ? VAL_MAX : v - 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/hex_seq_ctrl_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and
// a one-cycle pulse on the debounced press (1->0) transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic fall
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // Level flips on the Nth consecutive cycle that disagrees with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      meta <= key;
      sync <= meta;
      fall <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync;
        fall  <= ~sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hex_seq_ctrl.sv
// 1..5 sequencer shown on a seven-segment digit, stepped by a button in
// MANUAL, by a periodic timer in AUTO, frozen in ERROR on illegal switches.
module hex_seq_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_PERIOD     = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [2:0] value
);

  import hex_seq_pkg::*;

  localparam int unsigned TMR_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

  state_t             state;
  state_t             state_nxt;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   timer_nxt;
  logic [2:0]         value_nxt;
  logic               advance;
  logic               legal;
  logic               step;
  logic               clear;
  logic               clr_level;
  logic               unused_step_level;
  logic               unused_clr_fall;
  logic               unused_keys;

  assign legal       = (SW[9:2] == 8'd0);
  assign clear       = ~clr_level;
  assign unused_keys = ^KEY[3:2];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
    .clk   (CLOCK_50),
    .rst   (reset),
    .key   (KEY[0]),
    .level (unused_step_level),
    .fall  (step)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
    .clk   (CLOCK_50),
    .rst   (reset),
    .key   (KEY[1]),
    .level (clr_level),
    .fall  (unused_clr_fall)
  );

  // Next state, timer and value; clear overrides advances, illegal switches block them
  always_comb begin
    state_nxt = MANUAL;
    value_nxt = value;
    timer_nxt = timer;
    advance   = 1'b0;

    if (!legal)     state_nxt = ERROR;
    else if (SW[1]) state_nxt = AUTO;

    case (state)
      MANUAL: begin
        advance   = step;
        timer_nxt = '0;
      end
      AUTO: begin
        if (timer == TMR_LAST) begin
          advance   = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: ;
    endcase

    if (state_nxt == AUTO && state != AUTO) timer_nxt = '0;
    if (advance && legal) value_nxt = next_value(value, SW[0]);
    if (clear) begin
      value_nxt = VAL_MIN;
      timer_nxt = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= MANUAL;
      timer <= '0;
      value <= VAL_MIN;
      HEX0  <= SEG_1;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      value <= value_nxt;
      HEX0  <= (state_nxt == ERROR) ? ERR_SEG : seg_of(value_nxt);
    end
  end

endmodule

// File: tb/tb_hex_seq_ctrl.sv
// Directed bench for hex_seq_ctrl with a cycle-level reference model that
// is compared against the DUT outputs on every falling clock edge.
module tb_hex_seq_ctrl;

  localparam int N  = 4;
  localparam int AP = 8;
  localparam int MAN = 0, AUT = 1, ERR = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0;
  logic [2:0] value;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  hex_seq_ctrl #(.DEBOUNCE_CYCLES(N), .AUTO_PERIOD(AP)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .KEY      (KEY),
    .SW       (SW),
    .HEX0     (HEX0),
    .value    (value)
  );

  always #5 clk = ~clk;

  function automatic int exp_seg(input int v, input int mode);
    if (mode == ERR) return 7'b0000110;
    case (v)
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: raw key history windows, ring arithmetic for the value
  int m_value, m_mode, m_ticks;
  bit m_lvl0, m_lvl1, m_step;
  bit q0[$], q1[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_value = 1; m_mode = MAN; m_ticks = 0;
      m_lvl0 = 1; m_lvl1 = 1; m_step = 0;
      q0 = {}; q1 = {};
      for (int i = 0; i < N + 2; i++) begin
        q0.push_back(1'b1);
        q1.push_back(1'b1);
      end
    end else begin
      bit legal, adv, d0, d1;
      int nmode;
      legal = (SW[9:2] == 8'd0);
      adv = 0;
      if (m_mode == MAN) adv = m_step;
      else if (m_mode == AUT) begin
        m_ticks++;
        if (m_ticks == AP) begin adv = 1; m_ticks = 0; end
      end
      nmode = !legal ? ERR : (SW[1] ? AUT : MAN);
      if (nmode == AUT && m_mode != AUT) m_ticks = 0;
      if (adv && legal) m_value = SW[0] ? (m_value % 5) + 1 : ((m_value + 3) % 5) + 1;
      if (!m_lvl1) begin m_value = 1; m_ticks = 0; end
      m_mode = nmode;
      // Oldest N of the last N+2 raw samples are what the synchronizer has delivered
      q0.push_back(KEY[0]); q0.delete(0);
      q1.push_back(KEY[1]); q1.delete(0);
      d0 = 1; d1 = 1;
      for (int i = 0; i < N; i++) begin
        if (q0[i] == m_lvl0) d0 = 0;
        if (q1[i] == m_lvl1) d1 = 0;
      end
      m_step = 0;
      if (d0) begin m_lvl0 = !m_lvl0; m_step = !m_lvl0; end
      if (d1) m_lvl1 = !m_lvl1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cycle value", int'(value), m_value);
      check("cycle HEX0", int'(HEX0), exp_seg(m_value, m_mode));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int low, input int high);
    KEY[0] = 1'b0; cyc(low);
    KEY[0] = 1'b1; cyc(high);
  endtask

  initial begin
    int nchg, first, last, prev;
    reset = 1'b1; KEY = 4'hF; SW = 10'd0;
    cyc(3);
    reset = 1'b0;
    started = 1;
    check("reset value", int'(value), 1);
    check("reset HEX0", int'(HEX0), 7'b1111001);

    // Long hold counts as one press, down from 1 wraps to 5
    KEY[0] = 1'b0; cyc(10);
    KEY[0] = 1'b1; cyc(12);
    check("hold once value", int'(value), 5);
    check("hold once HEX0", int'(HEX0), 7'b0010010);

    // Clear, then five presses counting up
    SW = 10'b1;
    KEY[1] = 1'b0; cyc(6);
    KEY[1] = 1'b1; cyc(8);
    check("clear value", int'(value), 1);
    for (int i = 0; i < 5; i++) begin
      press(6, 8);
      check("up press value", int'(value), (i < 4) ? i + 2 : 1);
    end
    press(2, 10);
    check("glitch value", int'(value), 1);

    // Auto-run downward with ignored presses
    SW = 10'b10;
    nchg = 0; first = 0; last = 0; prev = 1;
    for (int i = 1; i <= 41; i++) begin
      cyc(1);
      KEY[0] = !(i >= 3 && i < 10);
      if (int'(value) != prev) begin
        nchg++;
        if (first == 0) first = i;
        last = i;
        prev = int'(value);
      end
    end
    check("auto advances", nchg, 5);
    check("auto first advance", first, 9);
    check("auto last advance", last, 41);
    check("auto final value", int'(value), 1);

    // Illegal switch on the wrap cycle: error wins, value held
    cyc(7);
    SW = 10'b0000100010;
    cyc(1);
    check("error HEX0", int'(HEX0), 7'b0000110);
    check("error value", int'(value), 1);
    cyc(2);
    SW = 10'b10;
    cyc(1);
    check("resume HEX0", int'(HEX0), 7'b1111001);
    cyc(7);
    check("resume before advance", int'(value), 1);
    cyc(1);
    check("resume first advance", int'(value), 5);

    // Clear held while stepping keeps value at 1
    SW = 10'b1;
    KEY[1] = 1'b0; cyc(2);
    press(6, 8);
    check("clear beats step", int'(value), 1);
    KEY[1] = 1'b1; cyc(10);
    press(6, 8);
    check("step after clear", int'(value), 2);

    // Async reset mid-period and mid-debounce
    SW = 10'b10;
    cyc(4);
    check("pre-reset value", int'(value), 2);
    KEY[0] = 1'b0; cyc(2);
    #2 reset = 1'b1;
    #1;
    check("async reset HEX0", int'(HEX0), 7'b1111001);
    check("async reset value", int'(value), 1);
    KEY[0] = 1'b1;
    cyc(2);
    reset = 1'b0;
    SW = 10'b1;
    cyc(10);
    check("no step after reset", int'(value), 1);
    check("post reset HEX0", int'(HEX0), 7'b1111001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
